// File: rtl/npe_tile_sched.sv
// Tile scheduler for the NPE core: walks a layer tile by tile, issuing one compute
// pulse per tile with that tile's base addresses, and guards each tile with a watchdog.
module npe_tile_sched #(
  parameter int unsigned TO_WIDTH = 16,
  parameter int unsigned TIMEOUT  = 16'hFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [7:0]  i_tile_num,
  input  logic [11:0] i_addr_start_d,
  input  logic [11:0] i_addr_start_s,
  input  logic [12:0] i_addr_start_w,
  input  logic [11:0] i_step_d,
  input  logic [11:0] i_step_s,
  input  logic [12:0] i_step_w,
  input  logic        i_calculate_end,
  output logic        o_calculate_enable,
  output logic [11:0] o_addr_start_d,
  output logic [11:0] o_addr_start_s,
  output logic [12:0] o_addr_start_w,
  output logic        o_b_first_tiling,
  output logic        o_b_last_tiling,
  output logic [7:0]  o_tile_idx,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StNext,
    StDone
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;

  logic [7:0]          r_tile_num;
  logic [11:0]         r_step_d;
  logic [11:0]         r_step_s;
  logic [12:0]         r_step_w;
  logic [11:0]         r_addr_d;
  logic [11:0]         r_addr_s;
  logic [12:0]         r_addr_w;
  logic [7:0]          r_tile_idx;
  logic                r_first;
  logic                r_last;
  logic                r_err;
  logic [TO_WIDTH-1:0] r_wd;

  logic                w_timeout;
  logic                w_load;
  logic                w_advance;
  logic                w_set_err;
  logic [7:0]          w_idx_inc;

  // The watchdog counts completed WAIT cycles, so TIMEOUT-1 marks the final one.
  assign w_timeout = (r_wd == TO_WIDTH'(TIMEOUT - 1));
  assign w_idx_inc = r_tile_idx + 8'd1;

  assign w_load    = (r_state == StIdle) && i_start && !i_abort;
  assign w_advance = (r_state == StNext) && !i_abort;
  assign w_set_err = (r_state == StWait) && !i_calculate_end && w_timeout && !i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = (i_tile_num == 8'd0) ? StDone : StIssue;
        end
      end
      StIssue: w_state_nxt = StWait;
      StWait: begin
        if (i_calculate_end) begin
          w_state_nxt = r_last ? StDone : StNext;
        end else if (w_timeout) begin
          w_state_nxt = StDone;
        end
      end
      StNext:  w_state_nxt = StIssue;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    // Abort outranks every other transition, including a same-cycle end pulse.
    if (i_abort) begin
      w_state_nxt = StIdle;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tile_num <= '0;
      r_step_d   <= '0;
      r_step_s   <= '0;
      r_step_w   <= '0;
      r_addr_d   <= '0;
      r_addr_s   <= '0;
      r_addr_w   <= '0;
      r_tile_idx <= '0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
    end else if (w_load) begin
      r_tile_num <= i_tile_num;
      r_step_d   <= i_step_d;
      r_step_s   <= i_step_s;
      r_step_w   <= i_step_w;
      r_addr_d   <= i_addr_start_d;
      r_addr_s   <= i_addr_start_s;
      r_addr_w   <= i_addr_start_w;
      r_tile_idx <= '0;
      r_first    <= 1'b1;
      r_last     <= (i_tile_num == 8'd1);
      r_err      <= 1'b0;
    end else if (w_advance) begin
      // Address sums wrap naturally at the port width.
      r_addr_d   <= r_addr_d + r_step_d;
      r_addr_s   <= r_addr_s + r_step_s;
      r_addr_w   <= r_addr_w + r_step_w;
      r_tile_idx <= w_idx_inc;
      r_first    <= 1'b0;
      r_last     <= (w_idx_inc == (r_tile_num - 8'd1));
    end else if (w_set_err) begin
      r_err      <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd <= '0;
    end else if (r_state == StWait) begin
      r_wd <= r_wd + TO_WIDTH'(1);
    end else begin
      r_wd <= '0;
    end
  end

  assign o_calculate_enable = (r_state == StIssue);
  assign o_busy             = (r_state != StIdle);
  assign o_done             = (r_state == StDone);
  assign o_addr_start_d     = r_addr_d;
  assign o_addr_start_s     = r_addr_s;
  assign o_addr_start_w     = r_addr_w;
  assign o_b_first_tiling   = r_first;
  assign o_b_last_tiling    = r_last;
  assign o_tile_idx         = r_tile_idx;
  assign o_err              = r_err;

endmodule

// File: tb/tb_npe_tile_sched.sv
// Directed bench for npe_tile_sched: table of layer configurations plus hand-written
// sequences for timeout, abort, ignored start and asynchronous reset.
module tb_npe_tile_sched;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [7:0]  i_tile_num;
  logic [11:0] i_addr_start_d;
  logic [11:0] i_addr_start_s;
  logic [12:0] i_addr_start_w;
  logic [11:0] i_step_d;
  logic [11:0] i_step_s;
  logic [12:0] i_step_w;
  logic        i_calculate_end;
  logic        o_calculate_enable;
  logic [11:0] o_addr_start_d;
  logic [11:0] o_addr_start_s;
  logic [12:0] o_addr_start_w;
  logic        o_b_first_tiling;
  logic        o_b_last_tiling;
  logic [7:0]  o_tile_idx;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_chk  = 0;
  int n_fail = 0;
  int n_en   = 0;
  int n_done = 0;

  npe_tile_sched #(
    .TO_WIDTH (16),
    .TIMEOUT  (20)
  ) u_dut (
    .i_clk              (i_clk),
    .i_rst_n            (i_rst_n),
    .i_start            (i_start),
    .i_abort            (i_abort),
    .i_tile_num         (i_tile_num),
    .i_addr_start_d     (i_addr_start_d),
    .i_addr_start_s     (i_addr_start_s),
    .i_addr_start_w     (i_addr_start_w),
    .i_step_d           (i_step_d),
    .i_step_s           (i_step_s),
    .i_step_w           (i_step_w),
    .i_calculate_end    (i_calculate_end),
    .o_calculate_enable (o_calculate_enable),
    .o_addr_start_d     (o_addr_start_d),
    .o_addr_start_s     (o_addr_start_s),
    .o_addr_start_w     (o_addr_start_w),
    .o_b_first_tiling   (o_b_first_tiling),
    .o_b_last_tiling    (o_b_last_tiling),
    .o_tile_idx         (o_tile_idx),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .o_err              (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Pulse counters sampled mid-cycle; the main thread compares snapshots.
  always @(negedge i_clk) begin
    if (o_calculate_enable) n_en <= n_en + 1;
    if (o_done) n_done <= n_done + 1;
  end

  typedef struct {
    int          tiles;
    logic [11:0] bd;
    logic [11:0] sd;
    logic [11:0] bs;
    logic [11:0] ss;
    logic [12:0] bw;
    logic [12:0] sw;
    logic [11:0] exp_last_d;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_inputs(input vec_t v);
    i_tile_num     = 8'(v.tiles);
    i_addr_start_d = v.bd;
    i_step_d       = v.sd;
    i_addr_start_s = v.bs;
    i_step_s       = v.ss;
    i_addr_start_w = v.bw;
    i_step_w       = v.sw;
  endtask

  task automatic scramble_inputs();
    i_tile_num     = 8'd7;
    i_addr_start_d = 12'h5A5;
    i_step_d       = 12'h001;
    i_addr_start_s = 12'h3C3;
    i_step_s       = 12'h002;
    i_addr_start_w = 13'h0F0F;
    i_step_w       = 13'h0003;
  endtask

  task automatic run_layer(input vec_t v, input string tag);
    int          en0;
    int          dn0;
    int          waited;
    bit          got;
    logic [11:0] ed;
    logic [11:0] es;
    logic [12:0] ew;
    en0 = n_en;
    dn0 = n_done;
    load_inputs(v);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    scramble_inputs();
    chk({tag, " busy after start"}, 32'(o_busy), 32'd1);
    if (v.tiles == 0) begin
      chk({tag, " done after start"}, 32'(o_done), 32'd1);
      chk({tag, " addr_d loaded"}, 32'(o_addr_start_d), 32'(v.bd));
      tick();
    end else begin
      for (int k = 0; k < v.tiles; k++) begin
        got    = 1'b0;
        waited = 0;
        for (int c = 0; c < 8; c++) begin
          if (o_calculate_enable) begin
            got = 1'b1;
            break;
          end
          waited++;
          tick();
        end
        chk({tag, " enable seen"}, 32'(got), 32'd1);
        chk({tag, " issue latency"}, 32'(waited), 32'd0);
        ed = v.bd + 12'(k) * v.sd;
        es = v.bs + 12'(k) * v.ss;
        ew = v.bw + 13'(k) * v.sw;
        chk({tag, " addr_d"}, 32'(o_addr_start_d), 32'(ed));
        chk({tag, " addr_s"}, 32'(o_addr_start_s), 32'(es));
        chk({tag, " addr_w"}, 32'(o_addr_start_w), 32'(ew));
        chk({tag, " tile_idx"}, 32'(o_tile_idx), 32'(k));
        chk({tag, " first flag"}, 32'(o_b_first_tiling), 32'(k == 0));
        chk({tag, " last flag"}, 32'(o_b_last_tiling), 32'(k == v.tiles - 1));
        if (k == v.tiles - 1) begin
          chk({tag, " last addr_d"}, 32'(o_addr_start_d), 32'(v.exp_last_d));
        end
        repeat (10) tick();
        chk({tag, " enable low in wait"}, 32'(o_calculate_enable), 32'd0);
        chk({tag, " addr_d stable"}, 32'(o_addr_start_d), 32'(ed));
        i_calculate_end = 1'b1;
        tick();
        i_calculate_end = 1'b0;
        if (k == v.tiles - 1) begin
          chk({tag, " done after end"}, 32'(o_done), 32'd1);
          tick();
        end else begin
          chk({tag, " no done mid-layer"}, 32'(o_done), 32'd0);
          tick();
        end
      end
    end
    chk({tag, " idle after done"}, 32'(o_busy), 32'd0);
    chk({tag, " done is a pulse"}, 32'(o_done), 32'd0);
    chk({tag, " enable count"}, 32'(n_en - en0), 32'(v.tiles));
    chk({tag, " done count"}, 32'(n_done - dn0), 32'd1);
  endtask

  initial begin
    int   en0;
    int   dn0;
    vec_t v;

    vecs[0] = '{3, 12'h100, 12'h040, 12'h200, 12'h010, 13'h0800, 13'h0100, 12'h180};
    vecs[1] = '{1, 12'h123, 12'h111, 12'h456, 12'h222, 13'h1789, 13'h0333, 12'h123};
    vecs[2] = '{2, 12'hFC0, 12'h080, 12'hFFF, 12'h001, 13'h1FF0, 13'h0020, 12'h040};
    vecs[3] = '{0, 12'h055, 12'h010, 12'h066, 12'h010, 13'h0077, 13'h0010, 12'h055};
    vecs[4] = '{4, 12'hA00, 12'h300, 12'h010, 12'h7F0, 13'h1000, 13'h0C00, 12'h300};

    i_rst_n         = 1'b0;
    i_start         = 1'b0;
    i_abort         = 1'b0;
    i_calculate_end = 1'b0;
    load_inputs(vecs[0]);
    repeat (3) tick();
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset addr_d", 32'(o_addr_start_d), 32'd0);
    chk("reset addr_w", 32'(o_addr_start_w), 32'd0);
    chk("reset flags", 32'({o_b_first_tiling, o_b_last_tiling}), 32'd0);
    chk("reset idx/err/done/en", 32'({o_tile_idx, o_err, o_done, o_calculate_enable}), 32'd0);
    i_rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_layer(vecs[i], $sformatf("vec%0d", i));
      repeat (2) tick();
      chk($sformatf("vec%0d outputs hold in idle", i), 32'(o_addr_start_d),
          32'(vecs[i].exp_last_d));
    end

    // Timeout: no end pulse for 20 WAIT cycles.
    v = '{2, 12'h010, 12'h010, 12'h020, 12'h010, 13'h0030, 13'h0010, 12'h020};
    load_inputs(v);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("timeout enable", 32'(o_calculate_enable), 32'd1);
    repeat (20) tick();
    chk("timeout not yet", 32'({o_done, o_err, o_busy}), 32'b001);
    tick();
    chk("timeout done+err", 32'({o_done, o_err}), 32'b11);
    tick();
    chk("err sticky in idle", 32'({o_busy, o_err}), 32'b01);

    // New start clears err; end pulse coinciding with the timeout cycle wins.
    v.tiles = 1;
    load_inputs(v);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("start clears err", 32'(o_err), 32'd0);
    repeat (20) tick();
    i_calculate_end = 1'b1;
    tick();
    i_calculate_end = 1'b0;
    chk("end beats timeout", 32'({o_done, o_err}), 32'b10);
    tick();

    // Abort in WAIT of tile 1 together with an end pulse; also a stray start in WAIT.
    load_inputs(vecs[0]);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    i_tile_num = 8'd1;
    i_start    = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_calculate_end = 1'b1;
    tick();
    i_calculate_end = 1'b0;
    tick();
    chk("abort seq tile1 enable", 32'(o_calculate_enable), 32'd1);
    chk("abort seq tile1 idx", 32'(o_tile_idx), 32'd1);
    chk("abort seq tile1 not last", 32'(o_b_last_tiling), 32'd0);
    repeat (2) tick();
    en0 = n_en;
    dn0 = n_done;
    i_abort         = 1'b1;
    i_calculate_end = 1'b1;
    tick();
    i_abort         = 1'b0;
    i_calculate_end = 1'b0;
    chk("abort to idle", 32'({o_busy, o_done, o_err}), 32'b000);
    repeat (30) tick();
    chk("abort no enables", 32'(n_en - en0), 32'd0);
    chk("abort no done", 32'(n_done - dn0), 32'd0);
    run_layer(vecs[2], "post-abort");

    // Asynchronous reset mid-layer.
    load_inputs(vecs[4]);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(o_busy), 32'd0);
    chk("async reset addr_d", 32'(o_addr_start_d), 32'd0);
    chk("async reset first", 32'(o_b_first_tiling), 32'd0);
    #2;
    i_rst_n = 1'b1;
    en0 = n_en;
    repeat (20) tick();
    chk("post-reset stays idle", 32'(o_busy), 32'd0);
    chk("post-reset no enables", 32'(n_en - en0), 32'd0);
    run_layer(vecs[1], "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
